// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the IF/ID fetch queue
package fetch_queue_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    SLOT_WAIT = 1'b1
  } fq_state_e;

  // Pointer update selected by the top for each cycle.
  typedef enum logic [1:0] {
    PTR_NORMAL    = 2'd0,
    PTR_CLEAR     = 2'd1,
    PTR_KEEP_NEXT = 2'd2
  } ptr_op_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_queue_ptr.sv
// rtl/fetch_queue_ptr.sv - read/write pointer and occupancy arithmetic for fetch_queue
module fetch_queue_ptr
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  ptr_op_e       op,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [CW-1:0] count
);

  // DEPTH is a power of two, so plain PW-bit addition wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        PTR_CLEAR: begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end
        PTR_KEEP_NEXT: begin
          rd_ptr <= rd_ptr + PW'(1);
          wr_ptr <= rd_ptr + PW'(2);
          count  <= CW'(1);
        end
        default: begin
          rd_ptr <= rd_ptr + PW'(pop);
          wr_ptr <= wr_ptr + PW'(push);
          count  <= count + CW'(push) - CW'(pop);
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry IF/ID instruction queue with trap flush and branch redirect
// Optional delay-slot retention on redirect is built when DELAY_SLOT_EN is defined.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int PC_W    = 30,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_tag,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_tag,
  input  logic               redirect,
  input  logic               trap,
  output logic [CW-1:0]      count
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  fq_state_e     state;
  ptr_op_e       op;
  logic          push;
  logic          pop;
  logic          enter_wait;

  // Handshakes see only registered occupancy, so no input reaches an output.
  assign if_ready = (count != CW'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  always_comb begin
    op         = PTR_NORMAL;
    enter_wait = 1'b0;
    if (trap) begin
      op = PTR_CLEAR;
    end else if (redirect && pop) begin
`ifdef DELAY_SLOT_EN
      if (count > CW'(1)) begin
        op = PTR_KEEP_NEXT;
      end else if (!push) begin
        enter_wait = 1'b1;
      end
`else
      op = PTR_CLEAR;
`endif
    end
  end

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (trap) begin
      state <= RUN;
    end else if (enter_wait) begin
      state <= SLOT_WAIT;
    end else if (state == SLOT_WAIT && push) begin
      state <= RUN;
    end
  end

  // A push is stored only when the pointers advance normally; flushes drop it.
  always_ff @(posedge clk) begin
    if (push && op == PTR_NORMAL) begin
      mem[wr_ptr] <= '{pc: if_pc, instr: if_instr, tag: if_tag};
    end
  end

  assign id_pc    = id_valid ? mem[rd_ptr].pc    : '0;
  assign id_instr = id_valid ? mem[rd_ptr].instr : INSTR_W'(NOP_INSTR);
  assign id_tag   = id_valid ? mem[rd_ptr].tag   : 1'b0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue (DELAY_SLOT_EN aware)
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               if_valid, if_ready, if_tag;
  logic               id_valid, id_ready, id_tag;
  logic               redirect, trap;
  logic [PC_W-1:0]    if_pc, id_pc;
  logic [INSTR_W-1:0] if_instr, id_instr;
  logic [CW-1:0]      count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               tag;
  } ent_t;

  ent_t sb[$];

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_tag   (if_tag),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_tag   (id_tag),
    .redirect (redirect),
    .trap     (trap),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the scoreboard, compare pops and post-edge state.
  task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic rdy,
                      input logic redir, input logic trp);
    ent_t e, h;
    logic push, pop;
    e.pc    = pc;
    e.instr = $urandom;
    e.tag   = 1'($urandom_range(0, 1));
    if_valid = v; if_pc = pc; if_instr = e.instr; if_tag = e.tag;
    id_ready = rdy; redirect = redir; trap = trp;
    push = v && (sb.size() != DEPTH) && !rst;
    pop  = rdy && (sb.size() != 0) && !rst;
    if (pop) begin
      h = sb.pop_front();
      check("pop_pc", id_pc, h.pc);
      check("pop_instr", id_instr, h.instr);
      check("pop_tag", id_tag, h.tag);
    end
    if (rst || trp) begin
      sb.delete();
    end else if (redir && pop) begin
`ifdef DELAY_SLOT_EN
      if (sb.size() != 0) begin
        h = sb[0];
        sb.delete();
        sb.push_back(h);
      end else if (push) begin
        sb.push_back(e);
      end
`else
      sb.delete();
`endif
    end else if (push) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0; id_ready = 1'b0; redirect = 1'b0; trap = 1'b0;
    check("count", count, sb.size());
    check("if_ready", if_ready, sb.size() != DEPTH);
    check("id_valid", id_valid, sb.size() != 0);
    if (sb.size() == 0) begin
      check("empty_pc", id_pc, 0);
      check("empty_instr", id_instr, 0);
      check("empty_tag", id_tag, 0);
    end else begin
      check("head_pc", id_pc, sb[0].pc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 'h3ff, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; if_tag = 1'b0;
    id_ready = 1'b0; redirect = 1'b0; trap = 1'b0;
    do_reset();
    check("reset_if_ready", if_ready, 1);
    check("reset_count", count, 0);

    // Fill under stall, hold offer while full, then drain in order.
    step(1'b1, 'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h11, 1'b0, 1'b0, 1'b0);
    check("stall_head", id_pc, 'h10);
    step(1'b1, 'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h13, 1'b0, 1'b0, 1'b0);
    check("full_if_ready", if_ready, 0);
    check("full_count", count, DEPTH);
    step(1'b1, 'h14, 1'b0, 1'b0, 1'b0);
    check("full_head_stable", id_pc, 'h10);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("drained_instr", id_instr, 0);

    // Streaming at count 1.
    step(1'b1, 'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, PC_W'('h31 + i), 1'b1, 1'b0, 1'b0);
      check("stream_count", count, 1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Trap flush drops a same-cycle push.
    step(1'b1, 'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h99, 1'b0, 1'b0, 1'b1);
    check("trap_count", count, 0);
    check("trap_valid", id_valid, 0);
    step(1'b1, 'h42, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Redirect without pop is ignored.
    step(1'b1, 'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("redir_nopop_count", count, 1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef DELAY_SLOT_EN
    step(1'b1, 'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h52, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("ds_keep_count", count, 1);
    check("ds_keep_pc", id_pc, 'h51);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 'h60, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("ds_wait_state", dut.state, SLOT_WAIT);
    step(1'b1, 'h61, 1'b0, 1'b0, 1'b0);
    check("ds_slot_pc", id_pc, 'h61);
    check("ds_run_state", dut.state, RUN);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 'h70, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h71, 1'b1, 1'b1, 1'b0);
    check("ds_push_kept_pc", id_pc, 'h71);
    check("ds_push_state", dut.state, RUN);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("ds_wait_again", dut.state, SLOT_WAIT);
    do_reset();
    check("ds_rst_state", dut.state, RUN);
    check("ds_rst_if_ready", if_ready, 1);
`else
    step(1'b1, 'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h52, 1'b1, 1'b1, 1'b0);
    check("redir_flush_count", count, 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

    // Reset with entries queued.
    step(1'b1, 'h56, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h57, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("rst_count", count, 0);
    check("rst_valid", id_valid, 0);
    step(1'b1, 'h58, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry instruction queue between fetch and decode with valid/ready handshakes on both sides, a decoupled stall path, trap flush, and branch redirect with an optional delay slot. Fetch pushes {pc, instr, tag}, and decode pops from the head. A decode-side stall (load-use) only back-pressures fetch once the queue is full. The block sits in the IF/ID slot of the five-stage CPU.

## Interface
- PC_W, 30, PC width (word address, bits 31:2)
- INSTR_W, 32, instruction width
- DEPTH, 2, entry count; power of two, 2..8
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  fetch offers an entry
- if_ready  out  1  queue can accept; equals (count != DEPTH)
- if_pc  in  PC_W  fetched PC
- if_instr  in  INSTR_W  fetched instruction
- if_tag  in  1  per-instruction sideband (exception/sign flag)
- id_valid  out  1  head entry present
- id_ready  in  1  decode consumes head; low = stall
- id_pc  out  PC_W  head PC
- id_instr  out  INSTR_W  head instruction; all zeros (NOP) when empty
- id_tag  out  1  head sideband
- redirect  in  1  decode resolves a taken branch/jump on the entry popped this cycle
- trap  in  1  syscall/ERET/exception: flush everything
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- push = if_valid & if_ready; pop = id_valid & id_ready.
- Circular buffer, rd/wr pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count updates by +push −pop.
- Outputs come from registered storage and the head pointer. No combinational path from any input to any output. In particular, if_ready does not depend on id_ready.
- Empty: id_valid=0, id_pc=0, id_instr=0, id_tag=0.
- Priority: rst > trap > redirect > normal.
- trap: the next cycle has count=0, pointers equal, and state RUN. A same-cycle push is dropped.
- redirect is honoured only together with pop; redirect without pop is ignored.
- State machine (2 states):
  - RUN: normal operation.
  - SLOT_WAIT: the delay slot has not arrived yet. The next push is kept, then the state returns to RUN. Any other push in SLOT_WAIT is impossible by construction, because fetch resumes at the target only afterwards. trap or rst returns the state to RUN.

## Timing
- Push to id_valid latency: 1 cycle.
- A stalled head holds id_* stable until pop.
- Full: if_ready=0. Fetch must hold its offer.
- Push into a full queue cannot occur. Push and pop in the same cycle at count 1..DEPTH−1 leaves count unchanged.
- Reset values: if_ready=1, id_valid=0, id_pc=0, id_instr=0, id_tag=0, count=0, state RUN.
- rst during any state, including SLOT_WAIT, takes effect at the same edge and clears all of the above.

## Configuration
- DELAY_SLOT_EN defined: on redirect+pop, the entry immediately behind the popped one is retained as the delay slot and all younger entries are discarded.
  - If the queue is empty after the pop, a same-cycle push is retained instead.
  - If there is no such push either, the state goes to SLOT_WAIT.
- DELAY_SLOT_EN undefined: redirect+pop discards all remaining entries and any same-cycle push; count=0 next cycle. SLOT_WAIT is never entered.

## Structure
- Package fetch_queue_pkg holds:
  - state enum {RUN, SLOT_WAIT}
  - NOP_INSTR constant (32'h0)
  - entry struct {pc, instr, tag}, parametrised through the module
- Storage is a flat register array inside the module; no sub-module is needed.
- Optional sub-module fetch_queue_ptr holds the pointer/count arithmetic.

## Test plan
- Reset, then push PCs 0x10, 0x11 with id_ready=0: count=2, if_ready=0, id_pc=0x10. Raise id_ready: pops in order, count returns to 0, id_instr=0.
- Simultaneous push/pop at count=1 over 10 cycles: count stays 1, and each popped PC equals the PC pushed one cycle earlier.
- trap with count=2 and a same-cycle push: count=0 next cycle, id_valid=0, and the dropped PC never appears.
- With DELAY_SLOT_EN, queue {A, B, C}, pop A with redirect: the next cycle has count=1 and id_pc=B. C never appears.
- With DELAY_SLOT_EN, queue {A} only, pop A with redirect and no push: state SLOT_WAIT. The next push D gives id_pc=D, then state RUN.
- Without DELAY_SLOT_EN, queue {A, B}, pop A with redirect plus push E: count=0 next cycle. Assert rst mid-SLOT_WAIT in the macro-on build: all outputs return to their reset values.
